// File: rtl/cpu_pkg.sv
// Shared definitions for the Phase 1 control sequencer: opcodes, IR fields, FSM states.
// CTRL_MULDIV_EN selects whether mul/div decode as supported instructions.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_THREE   = 2'd1,
    CLS_UNARY   = 2'd2,
    CLS_MULDIV  = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RB   = 2'd1,
    SEL_RC   = 2'd2
  } rout_sel_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: classify = CLS_THREE;
      OP_NEG, OP_NOT:                  classify = CLS_UNARY;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV:                  classify = CLS_MULDIV;
`else
      OP_MUL, OP_DIV:                  classify = CLS_ILLEGAL;
`endif
      default:                         classify = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_sequencer_reg_select_decode.sv
// Register-file select: 4-to-N one-hot decode of ra (load) and rb/rc (bus drive).
module reg_select_decode
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                rin_en,
  input  rout_sel_e           rout_sel,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rc,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout
);

  // one-hot decode of the selected register fields
  always_comb begin
    rin  = '0;
    rout = '0;
    if (rin_en) begin
      rin = NUM_REGS'(1) << ra;
    end else begin
      rin = '0;
    end
    case (rout_sel)
      SEL_RB:  rout = NUM_REGS'(1) << rb;
      SEL_RC:  rout = NUM_REGS'(1) << rc;
      default: rout = '0;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hard-wired fetch/decode/execute strobe sequencer for the Phase 1 datapath.
// Define CTRL_MULDIV_EN to enable the mul/div LO/HI execute path.
module alu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_rdy,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                PCin,
  output logic                pc_increment,
  output logic                MARin,
  output logic                read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                RYin,
  output logic                Zhighin,
  output logic                Zlowin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPW-1:0]      op_code,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e     state_r;
  op_class_e  cls_s;
  logic [4:0] op_s;
  logic       rin_en_s;
  rout_sel_e  rout_sel_s;

  assign op_s  = ir[IR_OP_HI:IR_OP_LO];
  assign cls_s = classify(op_s);

  // state register and transitions; clr drops straight back to IDLE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= start ? T0 : IDLE;
        T0:      state_r <= T1;
        T1:      state_r <= mem_rdy ? T2 : T1;
        T2:      state_r <= T3;
        T3:      state_r <= (cls_s == CLS_ILLEGAL) ? IDLE : T4;
        T4:      state_r <= (cls_s == CLS_UNARY) ? IDLE : T5;
        T5:      state_r <= (cls_s == CLS_MULDIV) ? T6 : IDLE;
        T6:      state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // control word: pure decode of state and IR, so IDLE (and clr) yields all zeros
  always_comb begin
    {PCout, PCin, pc_increment, MARin, read, MDRin, MDRout, IRin} = 8'd0;
    {RYin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin}        = 7'd0;
    op_code    = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    rin_en_s   = 1'b0;
    rout_sel_s = SEL_NONE;
    busy       = (state_r != IDLE);
    case (state_r)
      T0: begin
        {PCout, MARin, pc_increment, Zlowin, Zhighin} = 5'b11111;
      end
      T1: begin
        Zlowout = 1'b1;
        read    = 1'b1;
        PCin    = mem_rdy;
        MDRin   = mem_rdy;
      end
      T2: begin
        {MDRout, IRin} = 2'b11;
      end
      T3: begin
        if (cls_s == CLS_THREE || cls_s == CLS_MULDIV) begin
          rout_sel_s = SEL_RB;
          RYin       = 1'b1;
        end else if (cls_s == CLS_UNARY) begin
          rout_sel_s = SEL_RB;
          op_code    = OPW'(op_s);
          {Zlowin, Zhighin} = 2'b11;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (cls_s == CLS_THREE || cls_s == CLS_MULDIV) begin
          rout_sel_s = SEL_RC;
          op_code    = OPW'(op_s);
          {Zlowin, Zhighin} = 2'b11;
        end else if (cls_s == CLS_UNARY) begin
          Zlowout  = 1'b1;
          rin_en_s = 1'b1;
          done     = 1'b1;
        end else begin
          done = 1'b0;
        end
      end
      T5: begin
        if (cls_s == CLS_THREE) begin
          Zlowout  = 1'b1;
          rin_en_s = 1'b1;
          done     = 1'b1;
        end else if (cls_s == CLS_MULDIV) begin
          {Zlowout, LOin} = 2'b11;
        end else begin
          done = 1'b0;
        end
      end
      T6: begin
        if (cls_s == CLS_MULDIV) begin
          {Zhighout, HIin, done} = 3'b111;
        end else begin
          done = 1'b0;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  reg_select_decode #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_select_decode (
    .rin_en   (rin_en_s),
    .rout_sel (rout_sel_s),
    .ra       (ir[IR_RA_HI:IR_RA_LO]),
    .rb       (ir[IR_RB_HI:IR_RB_LO]),
    .rc       (ir[IR_RC_HI:IR_RC_LO]),
    .rin      (Rin),
    .rout     (Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed-vector bench for alu_control_sequencer; each cycle compares the full control word.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        mem_rdy;
  logic [31:0] ir;
  logic PCout, PCin, pc_increment, MARin, read, MDRin, MDRout, IRin, RYin;
  logic Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, busy, done, illegal;
  logic [4:0]  op_code;
  logic [15:0] Rin, Rout;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [17:0] M_PCOUT   = 18'd1 << 17;
  localparam logic [17:0] M_PCIN    = 18'd1 << 16;
  localparam logic [17:0] M_PCINC   = 18'd1 << 15;
  localparam logic [17:0] M_MARIN   = 18'd1 << 14;
  localparam logic [17:0] M_READ    = 18'd1 << 13;
  localparam logic [17:0] M_MDRIN   = 18'd1 << 12;
  localparam logic [17:0] M_MDROUT  = 18'd1 << 11;
  localparam logic [17:0] M_IRIN    = 18'd1 << 10;
  localparam logic [17:0] M_RYIN    = 18'd1 << 9;
  localparam logic [17:0] M_ZHIN    = 18'd1 << 8;
  localparam logic [17:0] M_ZLIN    = 18'd1 << 7;
  localparam logic [17:0] M_ZHOUT   = 18'd1 << 6;
  localparam logic [17:0] M_ZLOUT   = 18'd1 << 5;
  localparam logic [17:0] M_HIIN    = 18'd1 << 4;
  localparam logic [17:0] M_LOIN    = 18'd1 << 3;
  localparam logic [17:0] M_BUSY    = 18'd1 << 2;
  localparam logic [17:0] M_DONE    = 18'd1 << 1;
  localparam logic [17:0] M_ILLEGAL = 18'd1;

  localparam logic [17:0] W_T0 = M_PCOUT | M_MARIN | M_PCINC | M_ZLIN | M_ZHIN | M_BUSY;
  localparam logic [17:0] W_T1 = M_ZLOUT | M_PCIN | M_READ | M_MDRIN | M_BUSY;
  localparam logic [17:0] W_T1_STALL = M_ZLOUT | M_READ | M_BUSY;
  localparam logic [17:0] W_T2 = M_MDROUT | M_IRIN | M_BUSY;

  wire [54:0] obs_s = {PCout, PCin, pc_increment, MARin, read, MDRin, MDRout, IRin,
                       RYin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin,
                       busy, done, illegal, op_code, Rin, Rout};

  alu_control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .PCin(PCin), .pc_increment(pc_increment), .MARin(MARin),
    .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .op_code(op_code), .Rin(Rin), .Rout(Rout),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] oh(input int n);
    logic [15:0] one;
    one = 16'd1;
    return one << n;
  endfunction

  function automatic logic [54:0] ew(input logic [17:0] cw, input logic [4:0] op,
                                     input logic [15:0] rin, input logic [15:0] rout);
    return {cw, op, rin, rout};
  endfunction

  // move to 1 ns after the next rising edge; inputs for the new cycle are driven here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [54:0] exp);
    #1;
    vectors++;
    assert (obs_s === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs_s, exp);
    end
  endtask

  // assumes the current cycle is IDLE; issues start and checks T0..T2 with no stall
  task automatic fetch(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " T0"}, ew(W_T0, 5'd0, 16'd0, 16'd0));
    step();
    chk({tag, " T1"}, ew(W_T1, 5'd0, 16'd0, 16'd0));
    step();
    chk({tag, " T2"}, ew(W_T2, 5'd0, 16'd0, 16'd0));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_rdy = 1'b1; ir = 32'd0;
    step();
    chk("reset", ew(18'd0, 5'd0, 16'd0, 16'd0));
    start = 1'b1;
    step();
    chk("start held in reset", ew(18'd0, 5'd0, 16'd0, 16'd0));
    start = 1'b0;
    clr = 1'b0;
    step();
    chk("idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    // shl r4, r3, r7
    ir = 32'h5A1B8000;
    fetch("shl");
    step();
    chk("shl T3", ew(M_RYIN | M_BUSY, 5'd0, 16'd0, oh(3)));
    step();
    chk("shl T4", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b01011, 16'd0, oh(7)));
    step();
    start = 1'b1;
    chk("shl T5 done", ew(M_ZLOUT | M_DONE | M_BUSY, 5'd0, oh(4), 16'd0));
    step();
    chk("start in done cycle ignored", ew(18'd0, 5'd0, 16'd0, 16'd0));
    step();
    start = 1'b0;
    chk("back-to-back T0", ew(W_T0, 5'd0, 16'd0, 16'd0));

    // same shl with a 3-cycle memory stall
    step();
    mem_rdy = 1'b0;
    chk("stall T1 #1", ew(W_T1_STALL, 5'd0, 16'd0, 16'd0));
    step();
    chk("stall T1 #2", ew(W_T1_STALL, 5'd0, 16'd0, 16'd0));
    step();
    chk("stall T1 #3", ew(W_T1_STALL, 5'd0, 16'd0, 16'd0));
    step();
    mem_rdy = 1'b1;
    chk("stall T1 ready", ew(W_T1, 5'd0, 16'd0, 16'd0));
    step();
    chk("stall T2", ew(W_T2, 5'd0, 16'd0, 16'd0));
    step();
    chk("stall T3", ew(M_RYIN | M_BUSY, 5'd0, 16'd0, oh(3)));
    step();
    chk("stall T4", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b01011, 16'd0, oh(7)));
    step();
    chk("stall T5 done", ew(M_ZLOUT | M_DONE | M_BUSY, 5'd0, oh(4), 16'd0));
    step();
    chk("stall idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    // not r2, r5
    ir = 32'h91280000;
    fetch("not");
    step();
    chk("not T3", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b10010, 16'd0, oh(5)));
    step();
    chk("not T4 done", ew(M_ZLOUT | M_DONE | M_BUSY, 5'd0, oh(2), 16'd0));
    step();
    chk("not idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    // mul r3, r7
    ir = 32'h781B8000;
    fetch("mul");
    step();
`ifdef CTRL_MULDIV_EN
    chk("mul T3", ew(M_RYIN | M_BUSY, 5'd0, 16'd0, oh(3)));
    step();
    chk("mul T4", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b01111, 16'd0, oh(7)));
    step();
    chk("mul T5 LO", ew(M_ZLOUT | M_LOIN | M_BUSY, 5'd0, 16'd0, 16'd0));
    step();
    chk("mul T6 HI done", ew(M_ZHOUT | M_HIIN | M_DONE | M_BUSY, 5'd0, 16'd0, 16'd0));
`else
    chk("mul T3 illegal", ew(M_ILLEGAL | M_BUSY, 5'd0, 16'd0, 16'd0));
`endif
    step();
    chk("mul idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    // unsupported opcode 11111
    ir = 32'hF8000000;
    fetch("ill");
    step();
    chk("ill T3", ew(M_ILLEGAL | M_BUSY, 5'd0, 16'd0, 16'd0));
    step();
    chk("ill idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    // sub r1, r2, r3 interrupted by clr in T4
    ir = 32'h20918000;
    fetch("sub");
    step();
    chk("sub T3", ew(M_RYIN | M_BUSY, 5'd0, 16'd0, oh(2)));
    step();
    chk("sub T4", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b00100, 16'd0, oh(3)));
    #2;
    clr = 1'b1;
    chk("clr async in T4", ew(18'd0, 5'd0, 16'd0, 16'd0));
    #1;
    clr = 1'b0;
    step();
    chk("after clr idle", ew(18'd0, 5'd0, 16'd0, 16'd0));
    fetch("sub2");
    step();
    chk("sub2 T3", ew(M_RYIN | M_BUSY, 5'd0, 16'd0, oh(2)));
    step();
    chk("sub2 T4", ew(M_ZLIN | M_ZHIN | M_BUSY, 5'b00100, 16'd0, oh(3)));
    step();
    chk("sub2 T5 done", ew(M_ZLOUT | M_DONE | M_BUSY, 5'd0, oh(1), 16'd0));
    step();
    chk("sub2 idle", ew(18'd0, 5'd0, 16'd0, 16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Hard-wired control sequencer that drives the Phase 1 datapath strobes. On `start` it fetches one instruction: PC to MAR, PC increment, memory read into MDR, MDR to IR. It then decodes the IR and sequences the execute steps for register-register ALU, unary and (optionally) multiply/divide instructions. It sits directly upstream of the datapath and replaces the hand-timed strobe sequences used in the datapath benches.

## Interface
Parameters:
- `NUM_REGS`, 16: general registers; width of the `Rin`/`Rout` one-hot buses.
- `OPW`, 5: opcode width (IR[31:27]).

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin one fetch/execute sequence; sampled only in IDLE.
- `mem_rdy`  in  1  memory read data valid on datapath `data_in`.
- `ir`  in  32  datapath IR contents; valid from T3 onward.
- `PCout`, `PCin`, `pc_increment`, `MARin`, `read`, `MDRin`, `MDRout`, `IRin`, `RYin`, `Zhighin`, `Zlowin`, `Zhighout`, `Zlowout`, `HIin`, `LOin`  out  1 each  datapath strobes.
- `op_code`  out  5  ALU operation.
- `Rin`  out  NUM_REGS  one-hot register load enables.
- `Rout`  out  NUM_REGS  one-hot register bus drivers.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the final execute step.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- IR fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
- Supported opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011 (three-operand); neg 10001, not 10010 (unary); mul 01111, div 10000 (macro-gated).
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Moore outputs. Each control word is a pure decode of the current state and `ir`, and it is held for the whole cycle. Every strobe not listed for a state is 0, and `op_code` is 00000.
- IDLE: `start`=1 goes to T0.
- T0: PCout, MARin, pc_increment, Zlowin, Zhighin. Goes to T1.
- T1: Zlowout, PCin, read, MDRin. Stays in T1 while `mem_rdy`=0. PCin and MDRin are asserted only in the T1 cycle where `mem_rdy`=1. Goes to T2 when `mem_rdy`=1.
- T2: MDRout, IRin. Goes to T3.
- T3, three-operand or mul/div: Rout[rb], RYin. Goes to T4.
- T3, unary: Rout[rb], op_code=op, Zlowin, Zhighin. Goes to T4.
- T3, unsupported opcode: `illegal`=1, no strobes. Goes to IDLE.
- T4, three-operand or mul/div: Rout[rc], op_code=op, Zlowin, Zhighin. Goes to T5.
- T4, unary: Zlowout, Rin[ra], `done`. Goes to IDLE.
- T5, three-operand: Zlowout, Rin[ra], `done`. Goes to IDLE.
- T5, mul/div: Zlowout, LOin. Goes to T6.
- T6, mul/div: Zhighout, HIin, `done`. Goes to IDLE.
- Bus exclusivity: at most one `*out` strobe or `Rout` bit is high in any cycle.
- `start` while busy is ignored; it is not queued.
- `clr` in any state, including mid-T1 wait: immediate return to IDLE with all outputs 0. The datapath register state is left as is.
- No timeout on `mem_rdy`; only `clr` escapes a stalled T1.

## Timing
- Reset values: state IDLE; every output 0, including `busy`, `done` and `illegal`.
- Start latency: `start` sampled high at edge n puts the FSM in T0 during cycle n+1.
- The three latencies below assume `mem_rdy` is high in the first T1 cycle; each cycle `mem_rdy` is held low adds one cycle.
  - Three-operand: T0–T5 is 6 cycles; `done` in the 6th.
  - Unary: 5 cycles.
  - mul/div: 7 cycles.
- The datapath captures on the edge ending each state. `ir` decode is first used in T3, one edge after IRin.
- Back-to-back: `start` high in the `done` cycle is not seen. The earliest new T0 is the cycle after the first IDLE cycle.

## Configuration
- `CTRL_MULDIV_EN` defined: mul/div are supported and take the T5/T6 LO/HI path.
- Undefined: opcodes 01111 and 10000 are unsupported and pulse `illegal` in T3. T6 is unreachable and need not be encoded.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode localparams;
  - the state enum;
  - the IR field bit positions.
- Natural sub-module: `reg_select_decode`. It takes the decoded state class and ra/rb/rc and produces the `Rin`/`Rout` one-hots (4-to-16 decode plus enable).

## Test plan
- shl, `ir`=0x5A1B8000 (ra=4, rb=3, rc=7), `mem_rdy` tied 1:
  - sequence T0–T5;
  - Rout[3] in T3; Rout[7] with `op_code`=01011 in T4; Rin[4] and `done` in T5;
  - 6 cycles total.
- Memory stall: `mem_rdy` low for 3 cycles in T1:
  - FSM holds T1 with `read`=1 and PCin=0 in those cycles;
  - `done` arrives 3 cycles later than the no-stall case.
- not, `ir`=0x91280000 (ra=2, rb=5):
  - Rout[5] with `op_code`=10010 in T3; Rin[2] and `done` in T4;
  - 5 cycles total.
- mul, `ir`=0x781B8000, with `CTRL_MULDIV_EN`: LOin in T5, HIin and `done` in T6. Without the macro: `illegal` in T3, then IDLE.
- Illegal, `ir`=0xF8000000: `illegal` in T3; no `Rin` bit is ever set; `done` stays 0.
- `clr` pulsed during T4: all outputs 0 asynchronously; `busy`=0; a following `start` runs a clean T0.
